// File: rtl/trace_buffer.sv
// Instruction-retire trace buffer: records PC, instruction, cycle stamp and a
// store flag per executed instruction into a FIFO drained over a debug port.
module trace_buffer #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [4:0]  CAPTURE_STATE = 5'd1
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic                     Clear,
  input  logic [4:0]               state,
  input  logic [63:0]              PCOut,
  input  logic [31:0]              Instr31_0,
  input  logic                     DMemWrite,
  input  logic                     TraceReady,
  output logic                     TraceValid,
  output logic [63:0]              TracePC,
  output logic [31:0]              TraceInstr,
  output logic [31:0]              TraceStamp,
  output logic                     TraceStore,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic [15:0]              DropCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 64 + 32 + 32 + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_count;
  logic [31:0]   r_stamp;
  logic          r_in_cap;

  logic          r_pend_valid;
  logic [63:0]   r_pend_pc;
  logic [31:0]   r_pend_instr;
  logic [31:0]   r_pend_stamp;
  logic          r_pend_store;

  logic          w_in_cap;
  logic          w_event;
  logic          w_flush;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_drop;
  logic [EW-1:0] w_push_data;
  logic [EW-1:0] w_head;

  // Only the first cycle of a CAPTURE_STATE visit counts as a new instruction.
  assign w_in_cap    = (state == CAPTURE_STATE);
  assign w_event     = Enable && w_in_cap && !r_in_cap;
  assign w_flush     = !Enable && r_pend_valid;
  assign w_push_req  = !Clear && ((w_event && r_pend_valid) || w_flush);
  assign w_push_data = {r_pend_pc, r_pend_instr, r_pend_stamp, r_pend_store | DMemWrite};

  // Debug port handshake: an entry transfers on any rising edge where
  // TraceValid and TraceReady are both high; TraceValid never waits on
  // TraceReady, and the head entry is stable until it transfers.
  assign w_pop  = !Clear && (r_count != '0) && TraceReady;
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_drop = w_push_req && !w_push;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_stamp      <= '0;
      r_in_cap     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_pend_instr <= '0;
      r_pend_stamp <= '0;
      r_pend_store <= 1'b0;
    end else if (Clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_stamp      <= '0;
      r_in_cap     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_pend_instr <= '0;
      r_pend_stamp <= '0;
      r_pend_store <= 1'b0;
    end else begin
      r_stamp  <= r_stamp + 32'd1;
      r_in_cap <= w_in_cap;

      if (w_event) begin
        r_pend_valid <= 1'b1;
        r_pend_pc    <= PCOut;
        r_pend_instr <= Instr31_0;
        r_pend_stamp <= r_stamp;
        r_pend_store <= 1'b0;
      end else if (r_pend_valid) begin
        if (Enable) r_pend_store <= r_pend_store | DMemWrite;
        else        r_pend_valid <= 1'b0;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Dropped entries never stall the core; they are only counted.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign TraceValid = (r_count != '0);
  assign {TracePC, TraceInstr, TraceStamp, TraceStore} = TraceValid ? w_head : '0;
  assign Count      = r_count;
  assign Overflow   = r_overflow;
  assign DropCount  = r_drop_count;

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: a cycle model feeds an expected queue
// that is compared against every entry the debug port hands out.
module tb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int EW    = 129;
  localparam logic [4:0] CAP = 5'd1;

  logic        clk;
  logic        Reset;
  logic        Enable;
  logic        Clear;
  logic [4:0]  state;
  logic [63:0] PCOut;
  logic [31:0] Instr31_0;
  logic        DMemWrite;
  logic        TraceReady;
  logic        TraceValid;
  logic [63:0] TracePC;
  logic [31:0] TraceInstr;
  logic [31:0] TraceStamp;
  logic        TraceStore;
  logic [4:0]  Count;
  logic        Overflow;
  logic [15:0] DropCount;

  int n_tests;
  int n_fail;

  logic drv_enable;
  logic drv_ready;

  logic [EW-1:0] exp_q[$];
  logic          m_in_cap;
  logic          m_pv;
  logic          m_pst;
  logic [63:0]   m_ppc;
  logic [31:0]   m_pins;
  logic [31:0]   m_pstamp;
  logic [31:0]   m_stamp;

  trace_buffer #(.DEPTH(DEPTH), .CAPTURE_STATE(CAP)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Enable     (Enable),
    .Clear      (Clear),
    .state      (state),
    .PCOut      (PCOut),
    .Instr31_0  (Instr31_0),
    .DMemWrite  (DMemWrite),
    .TraceReady (TraceReady),
    .TraceValid (TraceValid),
    .TracePC    (TracePC),
    .TraceInstr (TraceInstr),
    .TraceStamp (TraceStamp),
    .TraceStore (TraceStore),
    .Count      (Count),
    .Overflow   (Overflow),
    .DropCount  (DropCount)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_in_cap = 1'b0;
    m_pv     = 1'b0;
    m_pst    = 1'b0;
    m_ppc    = '0;
    m_pins   = '0;
    m_pstamp = '0;
    m_stamp  = '0;
  endtask

  task automatic model_push(input logic [EW-1:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
  endtask

  // Driver: one clock cycle, entered and left at a falling edge.
  task automatic step(input logic [4:0] st, input logic [63:0] pc,
                      input logic [31:0] ins, input logic dmw);
    logic          in_cap;
    logic          ev;
    logic [EW-1:0] e;
    state      = st;
    PCOut      = pc;
    Instr31_0  = ins;
    DMemWrite  = dmw;
    Enable     = drv_enable;
    TraceReady = drv_ready;
    #1;
    if (Clear) begin
      model_reset();
    end else begin
      if (drv_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({TraceValid, TracePC, TraceInstr, TraceStamp, TraceStore} !== {1'b1, e}) begin
          n_fail++;
          $display("FAIL pop_entry: got v=%0b pc=%h ins=%h stamp=%0d st=%0b, expected v=1 pc=%h ins=%h stamp=%0d st=%0b",
                   TraceValid, TracePC, TraceInstr, TraceStamp, TraceStore,
                   e[128:65], e[64:33], e[32:1], e[0]);
        end
      end else if (drv_ready) begin
        n_tests++;
        if (TraceValid !== 1'b0) begin
          n_fail++;
          $display("FAIL empty_valid: got TraceValid=%0b expected 0", TraceValid);
        end
      end
      in_cap = (st == CAP);
      ev     = drv_enable && in_cap && !m_in_cap;
      if (ev) begin
        if (m_pv) model_push({m_ppc, m_pins, m_pstamp, m_pst | dmw});
        m_ppc    = pc;
        m_pins   = ins;
        m_pstamp = m_stamp;
        m_pst    = 1'b0;
        m_pv     = 1'b1;
      end else if (drv_enable && m_pv) begin
        m_pst = m_pst | dmw;
      end else if (!drv_enable && m_pv) begin
        model_push({m_ppc, m_pins, m_pstamp, m_pst | dmw});
        m_pv = 1'b0;
      end
      m_in_cap = in_cap;
      m_stamp  = m_stamp + 32'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step(5'd0, 64'd0, 32'd0, 1'b0);
    Clear = 1'b0;
  endtask

  // One instruction through states 1 (held 'hold' cycles), 2, 3, 0.
  task automatic run_instr(input logic [63:0] pc, input logic [31:0] ins,
                           input int hold, input logic store);
    for (int i = 0; i < hold; i++) step(5'd1, pc, ins, 1'b0);
    step(5'd2, pc, ins, 1'b0);
    step(5'd3, pc, ins, store);
    step(5'd0, pc, ins, 1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Enable = 1'b0; Clear = 1'b0; state = '0; PCOut = '0;
    Instr31_0 = '0; DMemWrite = 1'b0; TraceReady = 1'b0;
    drv_enable = 1'b1; drv_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({TraceValid, TracePC, TraceInstr, TraceStamp, TraceStore} !== '0) begin
      n_fail++;
      $display("FAIL reset_trace: got v=%0b pc=%h ins=%h stamp=%h st=%0b expected all 0",
               TraceValid, TracePC, TraceInstr, TraceStamp, TraceStore);
    end
    n_tests++;
    if ({Count, Overflow, DropCount} !== '0) begin
      n_fail++;
      $display("FAIL reset_status: got count=%0d ovf=%0b drop=%0d expected 0 0 0", Count, Overflow, DropCount);
    end
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    step(5'd0, 64'd0, 32'h00500093, 1'b0);
    run_instr(64'd0, 32'h00500093, 1, 1'b0);
    step(5'd1, 64'd4, 32'h00A00113, 1'b0);
    n_tests++;
    if (Count !== 5'd1) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 1", Count);
    end
    n_tests++;
    if ({TraceValid, TracePC, TraceInstr, TraceStore} !== {1'b1, 64'd0, 32'h00500093, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_head: got v=%0b pc=%h ins=%h st=%0b expected v=1 pc=0 ins=00500093 st=0",
               TraceValid, TracePC, TraceInstr, TraceStore);
    end
    n_tests++;
    if (TraceStamp !== 32'd1) begin
      n_fail++; $display("FAIL basic_stamp: got %0d expected 1", TraceStamp);
    end
  endtask

  task automatic test_store();
    do_clear();
    run_instr(64'd8,  $urandom(), 1, 1'b1);
    run_instr(64'd12, $urandom(), 1, 1'b0);
    run_instr(64'd16, $urandom(), 1, 1'b0);
    n_tests++;
    if ({Count, TracePC, TraceStore} !== {5'd2, 64'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL store_head: got count=%0d pc=%h st=%0b expected count=2 pc=8 st=1", Count, TracePC, TraceStore);
    end
    drv_ready = 1'b1;
    step(5'd0, 64'd16, 32'd0, 1'b0);
    drv_ready = 1'b0;
    n_tests++;
    if ({TracePC, TraceStore} !== {64'd12, 1'b0}) begin
      n_fail++;
      $display("FAIL store_next: got pc=%h st=%0b expected pc=c st=0", TracePC, TraceStore);
    end
  endtask

  task automatic test_hold();
    do_clear();
    run_instr(64'h20, $urandom(), 5, 1'b0);
    run_instr(64'h24, $urandom(), 1, 1'b0);
    run_instr(64'h28, $urandom(), 1, 1'b0);
    n_tests++;
    if ({Count, TracePC, TraceStamp} !== {5'd2, 64'h20, 32'd0}) begin
      n_fail++;
      $display("FAIL hold_head: got count=%0d pc=%h stamp=%0d expected count=2 pc=20 stamp=0", Count, TracePC, TraceStamp);
    end
    drv_ready = 1'b1;
    step(5'd0, 64'h28, 32'd0, 1'b0);
    drv_ready = 1'b0;
    n_tests++;
    if ({TracePC, TraceStamp} !== {64'h24, 32'd8}) begin
      n_fail++;
      $display("FAIL hold_stamp: got pc=%h stamp=%0d expected pc=24 stamp=8", TracePC, TraceStamp);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i <= 20; i++)
      run_instr(64'h100 + 64'(4 * i), $urandom(), 1, 1'($urandom_range(0, 1)));
    n_tests++;
    if ({Count, Overflow, DropCount} !== {5'd16, 1'b1, 16'd4}) begin
      n_fail++;
      $display("FAIL ovf_status: got count=%0d ovf=%0b drop=%0d expected 16 1 4", Count, Overflow, DropCount);
    end
    drv_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (TracePC !== 64'h100 + 64'(4 * k)) begin
        n_fail++;
        $display("FAIL ovf_order: entry %0d got pc=%h expected %h", k, TracePC, 64'h100 + 64'(4 * k));
      end
      step(5'd0, 64'h150, 32'd0, 1'b0);
    end
    step(5'd0, 64'h150, 32'd0, 1'b0);
    drv_ready = 1'b0;
    n_tests++;
    if ({Count, Overflow} !== {5'd0, 1'b1}) begin
      n_fail++; $display("FAIL ovf_drained: got count=%0d ovf=%0b expected 0 1", Count, Overflow);
    end
  endtask

  task automatic test_clear();
    run_instr(64'h180, $urandom(), 1, 1'b0);
    run_instr(64'h184, $urandom(), 1, 1'b0);
    do_clear();
    n_tests++;
    if ({Count, TraceValid, Overflow, DropCount, TracePC} !== '0) begin
      n_fail++;
      $display("FAIL clear_state: got count=%0d v=%0b ovf=%0b drop=%0d pc=%h expected all 0",
               Count, TraceValid, Overflow, DropCount, TracePC);
    end
    run_instr(64'h190, $urandom(), 1, 1'b0);
    run_instr(64'h194, $urandom(), 1, 1'b0);
    n_tests++;
    if ({Count, TracePC, TraceStamp} !== {5'd1, 64'h190, 32'd0}) begin
      n_fail++;
      $display("FAIL clear_restart: got count=%0d pc=%h stamp=%0d expected 1 190 0", Count, TracePC, TraceStamp);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i <= 16; i++) run_instr(64'h200 + 64'(4 * i), $urandom(), 1, 1'b0);
    drv_ready = 1'b1;
    step(5'd1, 64'h244, $urandom(), 1'b0);
    drv_ready = 1'b0;
    n_tests++;
    if ({Count, Overflow, DropCount} !== {5'd16, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL full_pushpop: got count=%0d ovf=%0b drop=%0d expected 16 0 0", Count, Overflow, DropCount);
    end
    step(5'd2, 64'h244, 32'd0, 1'b0);
    step(5'd3, 64'h244, 32'd0, 1'b0);
    step(5'd0, 64'h244, 32'd0, 1'b0);
    drv_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (TracePC !== 64'h204 + 64'(4 * k)) begin
        n_fail++;
        $display("FAIL full_order: entry %0d got pc=%h expected %h", k, TracePC, 64'h204 + 64'(4 * k));
      end
      step(5'd0, 64'h244, 32'd0, 1'b0);
    end
    drv_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_clear();
    run_instr(64'h300, $urandom(), 1, 1'b0);
    run_instr(64'h304, $urandom(), 1, 1'b0);
    drv_enable = 1'b0;
    step(5'd0, 64'h304, 32'd0, 1'b1);
    n_tests++;
    if (Count !== 5'd2) begin
      n_fail++; $display("FAIL flush_push: got count=%0d expected 2", Count);
    end
    step(5'd1, 64'h308, 32'd0, 1'b1);
    n_tests++;
    if (Count !== 5'd2) begin
      n_fail++; $display("FAIL flush_idle: got count=%0d expected 2", Count);
    end
    drv_ready = 1'b1;
    step(5'd0, 64'h308, 32'd0, 1'b0);
    n_tests++;
    if ({TracePC, TraceStore} !== {64'h304, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_entry: got pc=%h st=%0b expected pc=304 st=1", TracePC, TraceStore);
    end
    step(5'd0, 64'h308, 32'd0, 1'b0);
    drv_ready  = 1'b0;
    drv_enable = 1'b1;
  endtask

  task automatic test_reset_mid_drain();
    do_clear();
    for (int i = 0; i < 5; i++) run_instr(64'h400 + 64'(4 * i), $urandom(), 1, 1'b0);
    drv_ready = 1'b1;
    step(5'd0, 64'h410, 32'd0, 1'b0);
    step(5'd0, 64'h410, 32'd0, 1'b0);
    #2 Reset = 1'b0;
    #1;
    n_tests++;
    if ({TraceValid, TracePC, TraceInstr, TraceStamp, TraceStore, Count, Overflow, DropCount} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%0b pc=%h ins=%h stamp=%h count=%0d expected all 0",
               TraceValid, TracePC, TraceInstr, TraceStamp, Count);
    end
    @(negedge clk);
    Reset = 1'b1;
    model_reset();
    drv_ready = 1'b0;
    run_instr(64'h500, $urandom(), 1, 1'b0);
    run_instr(64'h504, $urandom(), 1, 1'b0);
    n_tests++;
    if ({Count, TracePC, TraceStamp} !== {5'd1, 64'h500, 32'd0}) begin
      n_fail++;
      $display("FAIL post_reset: got count=%0d pc=%h stamp=%0d expected 1 500 0", Count, TracePC, TraceStamp);
    end
    drv_ready = 1'b1;
    step(5'd0, 64'h504, 32'd0, 1'b0);
    step(5'd0, 64'h504, 32'd0, 1'b0);
    drv_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_store();
    test_hold();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_flush();
    test_reset_mid_drain();
    n_tests++;
    if (Count !== 5'(exp_q.size())) begin
      n_fail++;
      $display("FAIL final_occupancy: got count=%0d expected %0d", Count, exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
